stopwatch_ctrl: RTL and testbench

- Downstream consumer of the board clock generator's divided output: a stopwatch counting MM:SS.cc in BCD, one count per rising edge of `tick_in`.
- `tick_in` is the generator's square-wave `clkout`, nominally 100 Hz.
- Runs entirely in the 50 MHz `clkin` domain. `tick_in` and the push-button inputs are synchronised and edge-detected; `tick_in` is never used as a clock.
- Drives six 7-segment digits plus BCD values for other stages.

---
 rtl/stopwatch_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: counts MM:SS.cc in BCD, one count per tick_in rise.
// tick_in and the buttons are synchronised and edge-detected in the clkin
// domain. The display shows either the live counters or a frozen lap snapshot,
// and feeds six registered 7-segment digit outputs.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | counters held at zero, waiting for start
// ST_RUN   | tick events advance the counters, lap toggles freeze
// ST_PAUSE | counters hold, a lap event can only release the freeze
module stopwatch_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_LIMIT      = 59,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       lap_hold,
    output logic       overflow,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [7:0] MIN_LIM_BCD = {4'(MIN_LIMIT / 10), 4'(MIN_LIMIT % 10)};
    localparam logic [6:0] SEG_ZERO    = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

    // Bit order of the conditioned inputs: {lap, clear, start, tick}
    logic [3:0]                   in_raw;
    logic [SYNC_STAGES-1:0][3:0]  sync_q, sync_d;
    logic [3:0]                   dly_q, dly_d;
    logic [3:0]                   ev;
    logic                         tick_ev, start_ev, clr_ev, lap_ev;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cs_q, cs_d, sec_q, sec_d, min_q, min_d;
    logic [23:0] snap_q, snap_d;
    logic        lap_hold_q, lap_hold_d;
    logic        ovf_q, ovf_d;
    logic [23:0] disp_q, disp_d;
    logic [5:0][6:0] hex_q, hex_d;

    assign in_raw   = {lap, clear, start_stop, tick_in};
    assign tick_ev  = ev[0];
    assign start_ev = ev[1];
    assign clr_ev   = ev[2];
    assign lap_ev   = ev[3];

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    // Synchroniser shift, delay flop and rising-edge event extraction
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_raw};
        dly_d  = sync_q[SYNC_STAGES-1];
        ev     = sync_q[SYNC_STAGES-1] & ~dly_q;
    end

    // Control FSM, BCD counters, lap snapshot and sticky overflow
    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        sec_d      = sec_q;
        min_d      = min_q;
        snap_d     = snap_q;
        lap_hold_d = lap_hold_q;
        ovf_d      = ovf_q;
        if (clr_ev) begin
            state_d    = ST_IDLE;
            cs_d       = 8'h00;
            sec_d      = 8'h00;
            min_d      = 8'h00;
            snap_d     = 24'h0;
            lap_hold_d = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cs_d  = 8'h00;
                    sec_d = 8'h00;
                    min_d = 8'h00;
                    if (start_ev) state_d = ST_RUN;
                end
                ST_RUN: begin
                    // Snapshot takes the pre-increment value when tick and lap coincide
                    if (lap_ev) begin
                        lap_hold_d = ~lap_hold_q;
                        if (!lap_hold_q) snap_d = {min_q, sec_q, cs_q};
                    end
                    if (tick_ev) begin
                        if (cs_q == 8'h99) begin
                            cs_d = 8'h00;
                            if (sec_q == 8'h59) begin
                                sec_d = 8'h00;
                                if (min_q == MIN_LIM_BCD) begin
                                    min_d = 8'h00;
                                    ovf_d = 1'b1;
                                end else begin
                                    min_d = bcd_inc(min_q);
                                end
                            end else begin
                                sec_d = bcd_inc(sec_q);
                            end
                        end else begin
                            cs_d = bcd_inc(cs_q);
                        end
                    end
                    if (start_ev) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (start_ev) state_d = ST_RUN;
                    if (lap_ev && lap_hold_q) lap_hold_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Display source select and segment decode, registered one cycle behind the counters
    always_comb begin
        disp_d = lap_hold_q ? snap_q : {min_q, sec_q, cs_q};
        for (int i = 0; i < 6; i++) begin
            hex_d[i] = seg_decode(disp_d[4*i +: 4]);
        end
    end

    // State, counter and display registers
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            dly_q      <= '0;
            state_q    <= ST_IDLE;
            cs_q       <= 8'h00;
            sec_q      <= 8'h00;
            min_q      <= 8'h00;
            snap_q     <= 24'h0;
            lap_hold_q <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= 24'h0;
            hex_q      <= {6{SEG_ZERO}};
        end else begin
            sync_q     <= sync_d;
            dly_q      <= dly_d;
            state_q    <= state_d;
            cs_q       <= cs_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            snap_q     <= snap_d;
            lap_hold_q <= lap_hold_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            hex_q      <= hex_d;
        end
    end

    assign cs_bcd   = disp_q[7:0];
    assign sec_bcd  = disp_q[15:8];
    assign min_bcd  = disp_q[23:16];
    assign running  = (state_q == ST_RUN);
    assign lap_hold = lap_hold_q;
    assign overflow = ovf_q;
    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign hex3     = hex_q[3];
    assign hex4     = hex_q[4];
    assign hex5     = hex_q[5];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed and random button/tick stimulus,
// expectations from a total-centisecond reference model, scoreboard monitor.
module tb_stopwatch_ctrl;

    localparam int SYNC    = 2;
    localparam int MIN_LIM = 1;
    localparam bit SEG_LOW = 1'b1;
    localparam int TOTAL   = (MIN_LIM + 1) * 6000;

    logic clkin = 1'b0;
    logic rst = 1'b0;
    logic tick_in = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [7:0] cs_bcd, sec_bcd, min_bcd;
    logic running, lap_hold, overflow;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

    stopwatch_ctrl #(
        .SYNC_STAGES(SYNC),
        .MIN_LIMIT(MIN_LIM),
        .SEG_ACTIVE_LOW(SEG_LOW)
    ) dut (
        .clkin(clkin), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap), .cs_bcd(cs_bcd), .sec_bcd(sec_bcd),
        .min_bcd(min_bcd), .running(running), .lap_hold(lap_hold),
        .overflow(overflow), .hex0(hex0), .hex1(hex1), .hex2(hex2),
        .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #10 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  mn;
        logic [7:0]  sc;
        logic [7:0]  cs;
        logic        run;
        logic        lh;
        logic        ovf;
        logic [41:0] hex;
    } obs_t;

    typedef struct {
        obs_t  val;
        int    issue;
        int    lat;
        string tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   bulk = 1'b1;
    bit   resync_req = 1'b0;

    // Reference model: elapsed time as plain centiseconds
    int   m_time = 0, m_snap = 0, m_mode = 0;   // mode 0 idle, 1 run, 2 pause
    bit   m_lap = 1'b0, m_ovf = 1'b0;
    obs_t m_prev;

    function automatic logic [6:0] seg(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F; 4: p = 7'h66;
            5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07; 8: p = 7'h7F; 9: p = 7'h6F;
            default: p = 7'h00;
        endcase
        return SEG_LOW ? ~p : p;
    endfunction

    function automatic logic [7:0] to_bcd(input int x);
        logic [3:0] t, o;
        t = 4'(x / 10);
        o = 4'(x % 10);
        return {t, o};
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        int t, c, s, m;
        t = m_lap ? m_snap : m_time;
        c = t % 100;
        s = (t / 100) % 60;
        m = t / 6000;
        o.cs  = to_bcd(c);
        o.sc  = to_bcd(s);
        o.mn  = to_bcd(m);
        o.run = (m_mode == 1);
        o.lh  = m_lap;
        o.ovf = m_ovf;
        o.hex = {seg(m / 10), seg(m % 10), seg(s / 10), seg(s % 10), seg(c / 10), seg(c % 10)};
        return o;
    endfunction

    function automatic void model_step(input bit t, input bit s, input bit c, input bit l);
        if (c) begin
            m_time = 0; m_snap = 0; m_lap = 1'b0; m_ovf = 1'b0; m_mode = 0;
        end else if (m_mode == 0) begin
            if (s) m_mode = 1;
        end else if (m_mode == 1) begin
            if (l) begin
                if (!m_lap) m_snap = m_time;
                m_lap = !m_lap;
            end
            if (t) begin
                m_time = m_time + 1;
                if (m_time == TOTAL) begin
                    m_time = 0;
                    m_ovf  = 1'b1;
                end
            end
            if (s) m_mode = 2;
        end else begin
            if (s) m_mode = 1;
            if (l && m_lap) m_lap = 1'b0;
        end
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.mn = min_bcd; o.sc = sec_bcd; o.cs = cs_bcd;
        o.run = running; o.lh = lap_hold; o.ovf = overflow;
        o.hex = {hex5, hex4, hex3, hex2, hex1, hex0};
        return o;
    endfunction

    task automatic push_if_changed(input string tag);
        obs_t n;
        int lat;
        n = model_obs();
        if (n != m_prev) begin
            lat = ({n.run, n.lh, n.ovf} != {m_prev.run, m_prev.lh, m_prev.ovf}) ? SYNC + 1 : SYNC + 2;
            sb_q.push_back('{n, cyc, lat, tag});
            m_prev = n;
        end
    endtask

    task automatic event_pulse(input bit t, input bit s, input bit c, input bit l,
                               input int hold, input string tag);
        @(negedge clkin);
        model_step(t, s, c, l);
        push_if_changed(tag);
        tick_in = t; start_stop = s; clear = c; lap = l;
        repeat (hold) @(negedge clkin);
        tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        repeat (12) @(negedge clkin);
    endtask

    task automatic resync(input string tag);
        m_prev = model_obs();
        sb_q.push_back('{m_prev, cyc, -1, tag});
        @(posedge clkin);
        #1;
        bulk = 1'b0;
        resync_req = 1'b1;
        repeat (4) @(negedge clkin);
    endtask

    task automatic bulk_ticks(input int n);
        @(posedge clkin);
        #1;
        bulk = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clkin);
            tick_in = 1'b1;
            model_step(1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clkin);
            tick_in = 1'b0;
        end
        repeat (10) @(negedge clkin);
        resync("bulk");
    endtask

    // Monitor: on any output change, let it settle, then pop and compare
    initial begin
        obs_t cur, last;
        exp_t e;
        int   chg;
        last = '0;
        forever begin
            @(negedge clkin);
            cur = sample();
            if (bulk) begin
                last = cur;
            end else if (resync_req) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL resync: no expectation queued, got %h", cur);
                end else begin
                    e = sb_q.pop_front();
                    if (cur !== e.val) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", e.tag, cur, e.val);
                    end
                end
                resync_req = 1'b0;
                last = cur;
            end else if (cur != last) begin
                chg = cyc;
                repeat (3) @(negedge clkin);
                cur = sample();
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h at cycle %0d, expected no change", cur, chg);
                end else begin
                    e = sb_q.pop_front();
                    if (cur !== e.val || (e.lat >= 0 && chg - e.issue != e.lat)) begin
                        errors++;
                        $display("FAIL %s: got %h latency %0d, expected %h latency %0d",
                                 e.tag, cur, chg - e.issue, e.val, e.lat);
                    end
                end
                last = cur;
            end
        end
    end

    // Stimulus
    initial begin
        bit t, s, c, l;
        int drain;
        #55 rst = 1'b1;
        repeat (5) @(negedge clkin);
        resync("reset_state");

        event_pulse(0, 1, 0, 0, 2, "start");
        for (int i = 0; i < 150; i++) event_pulse(1, 0, 0, 0, 1, "tick_run");

        event_pulse(0, 1, 0, 0, 1, "pause");
        for (int i = 0; i < 20; i++) event_pulse(1, 0, 0, 0, 2, "tick_paused");
        event_pulse(0, 1, 0, 0, 1, "resume");
        for (int i = 0; i < 5; i++) event_pulse(1, 0, 0, 0, 1, "tick_resumed");

        event_pulse(0, 0, 1, 0, 1, "clear_run");
        event_pulse(0, 1, 0, 0, 1, "start2");
        bulk_ticks(307);
        event_pulse(0, 0, 0, 1, 1, "lap_on");
        for (int i = 0; i < 100; i++) event_pulse(1, 0, 0, 0, 1, "tick_lapped");
        event_pulse(0, 0, 0, 1, 1, "lap_off");

        event_pulse(0, 0, 1, 0, 1, "clear_lap");
        event_pulse(0, 1, 0, 0, 1, "start3");
        bulk_ticks(TOTAL - 1);
        event_pulse(1, 0, 0, 0, 1, "wrap_overflow");
        event_pulse(0, 0, 1, 0, 1, "clear_overflow");

        event_pulse(0, 1, 0, 0, 1, "start4");
        bulk_ticks(1000);
        event_pulse(0, 1, 0, 0, 1, "pause_10s");
        event_pulse(0, 1, 1, 0, 1, "clear_start_pause");

        for (int i = 0; i < 200; i++) begin
            t = ($urandom_range(0, 1) == 0);
            s = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 5) == 0);
            if (!(t || s || c || l)) t = 1'b1;
            event_pulse(t, s, c, l, $urandom_range(1, 3), "random");
        end

        event_pulse(0, 0, 1, 0, 1, "clear5");
        event_pulse(0, 1, 0, 0, 1, "start5");
        for (int i = 0; i < 30; i++) event_pulse(1, 0, 0, 0, 1, "tick_pre_rst");

        @(posedge clkin);
        #3;
        rst = 1'b0;
        m_time = 0; m_snap = 0; m_mode = 0; m_lap = 1'b0; m_ovf = 1'b0;
        sb_q.push_back('{model_obs(), cyc, 0, "async_reset"});
        m_prev = model_obs();
        repeat (10) @(posedge clkin);
        #3;
        rst = 1'b1;
        repeat (10) @(negedge clkin);

        drain = 0;
        while ((sb_q.size() != 0 || resync_req) && drain < 300) begin
            @(negedge clkin);
            drain++;
        end
        if (sb_q.size() != 0 || resync_req) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations still pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
